// File: rtl/pe_array_cell.sv
// Output-stationary systolic PE: multiply-accumulates K_LEN valid beats, then emits a
// rounded-down, saturated, optionally ReLU'd result while forwarding operands downstream.
module pe_array_cell #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned K_LEN  = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [DATA_W-1:0] i_map,
    input  logic                     i_relu_en,
    output logic signed [DATA_W-1:0] o_weight,
    output logic signed [DATA_W-1:0] o_map,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_result_valid,
    output logic                     o_sat,
    output logic                     o_busy
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam logic [7:0] CNT_LAST = 8'(K_LEN - 1);
    localparam logic signed [ACC_W-1:0] RES_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    // Worst-case sum of K_LEN full-scale products must fit without wrapping.
    if (ACC_W < 2 * DATA_W + $clog2(K_LEN)) begin : g_acc_w_check
        $error("pe_array_cell: ACC_W too small for DATA_W and K_LEN");
    end

    if (K_LEN < 1 || K_LEN > 255) begin : g_k_len_check
        $error("pe_array_cell: K_LEN must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]                cnt_q, cnt_d;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  res_d;
    logic                      sat_d;
    logic                      res_load;
    logic                      fwd_valid_d;
    logic signed [DATA_W-1:0]  fwd_w_d, fwd_m_d;

    assign prod    = PW'(i_weight) * PW'(i_map);
    assign acc_sum = acc_q + ACC_W'(prod);
    assign shifted = acc_sum >>> FRAC;
    assign o_busy  = (state_q == StAcc);

    // Result of the final beat: saturate first, then ReLU; o_sat reflects saturation only.
    always_comb begin
        res_d = shifted[DATA_W-1:0];
        sat_d = 1'b0;
        if (shifted > RES_MAX) begin
            res_d = RES_MAX[DATA_W-1:0];
            sat_d = 1'b1;
        end else if (shifted < RES_MIN) begin
            res_d = RES_MIN[DATA_W-1:0];
            sat_d = 1'b1;
        end
        if (i_relu_en && res_d[DATA_W-1]) begin
            res_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_load    = 1'b0;
        fwd_valid_d = 1'b0;
        fwd_w_d     = '0;
        fwd_m_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StAcc;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StAcc: begin
                if (i_valid) begin
                    fwd_valid_d = 1'b1;
                    fwd_w_d     = i_weight;
                    fwd_m_d     = i_map;
                end
                // A start inside a run aborts it, even on what would be the final beat.
                if (i_start) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (i_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = StDone;
                        res_load = 1'b1;
                    end
                end
            end
            StDone: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = i_start ? StAcc : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            cnt_q          <= '0;
            o_weight       <= '0;
            o_map          <= '0;
            o_valid        <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_sat          <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            o_weight       <= fwd_w_d;
            o_map          <= fwd_m_d;
            o_valid        <= fwd_valid_d;
            o_result_valid <= res_load;
            if (res_load) begin
                o_result <= res_d;
                o_sat    <= sat_d;
            end
        end
    end

endmodule
